in_debounce_sync: RTL and testbench
===================================

// Module: in_debounce_sync
// PURPOSE
//  Front-end conditioning stage for a raw asynchronous input pin. It feeds the clean IN level
//  that the top-level capture register (reg1 <= IN) samples.
//  It synchronises the pin into CLK, then debounces it with a 4-state FSM and a stability counter.
//  It emits a clean level, one-cycle RISE/FALL pulses, a transition counter and a glitch counter.
// PARAMETERS
//  SYNC_STAGES      2   synchroniser depth, legal values >= 2
//  DEBOUNCE_CYCLES  16  consecutive stable synced samples required to accept a change (>= 2)
//  CNT_W            5   debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  EVT_W            8   width of EVT_CNT
//  GLITCH_W         8   width of GLITCH_CNT
// PORTS
//  CLK         in   1         clock, rising edge
//  RST         in   1         reset, asynchronous, active-low
//  IN_RAW      in   1         asynchronous raw input, may bounce
//  CLR         in   1         synchronous clear of EVT_CNT and GLITCH_CNT
//  OUT         out  1         debounced level; drives the consumer's IN
//  RISE        out  1         one-cycle pulse on accepted 0->1
//  FALL        out  1         one-cycle pulse on accepted 1->0
//  BUSY        out  1         1 while in a CHK state
//  EVT_CNT     out  EVT_W     accepted transitions, wraps modulo 2**EVT_W
//  GLITCH_CNT  out  GLITCH_W  rejected bounces, saturates at all-ones
// BEHAVIOUR
//  - Reset (RST=0): every flop is cleared asynchronously. OUT=RISE=FALL=BUSY=0, both counters are 0,
//    sync chain is all 0, FSM is in ST_LO, debounce counter is 0.
//  - Synchroniser: chain of SYNC_STAGES flops; s = last stage. The FSM looks only at s.
//  - FSM transitions (dcnt = debounce counter):
//    ST_LO:     s=1 -> ST_CHK_HI, dcnt<=1; otherwise stay in ST_LO.
//    ST_CHK_HI: s=0 -> ST_LO, dcnt<=0, glitch++.
//               s=1 and dcnt==DEBOUNCE_CYCLES-1 -> ST_HI, OUT<=1, RISE<=1, evt++.
//               otherwise dcnt++.
//    ST_HI:     s=0 -> ST_CHK_LO, dcnt<=1; otherwise stay in ST_HI.
//    ST_CHK_LO: s=1 -> ST_HI, dcnt<=0, glitch++.
//               s=0 and dcnt==DEBOUNCE_CYCLES-1 -> ST_LO, OUT<=0, FALL<=1, evt++.
//               otherwise dcnt++.
//  - Outputs are all registered. BUSY=1 exactly in ST_CHK_HI and ST_CHK_LO.
//  - RISE and FALL are high for exactly one cycle, coincident with the OUT change, never both at once.
//  - Latency: OUT changes DEBOUNCE_CYCLES edges after s changes.
//    It changes SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples a stable IN_RAW.
//  - A bounce that returns inside the window costs no extra latency: the FSM re-enters the idle
//    state and the next change restarts dcnt from 1.
//  - Counters: EVT_CNT wraps from all-ones to 0. GLITCH_CNT holds at all-ones once reached.
//    CLR=1 zeroes both counters; CLR wins over a same-cycle increment. CLR does not affect the FSM or OUT.
//  - Reset mid-operation aborts any check and returns the block to ST_LO with OUT=0.
//    If IN_RAW is high after RST releases, it is treated as a fresh rising change: RISE fires and EVT_CNT=1.
//  - Width rule: dcnt never exceeds DEBOUNCE_CYCLES-1. Parameter legality is checked at elaboration.
// TESTING  (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
//  1. Hold RST=0, IN_RAW=0, then release RST; run 50 cycles -> OUT, RISE, FALL, BUSY = 0;
//     EVT_CNT=GLITCH_CNT=0.
//  2. IN_RAW 0->1, held -> OUT=1 at the 18th edge after the first sampling edge; RISE=1 for that single cycle;
//     BUSY=1 for the preceding 15 cycles; EVT_CNT=1.
//  3. From OUT=0, IN_RAW high for 10 cycles then low -> OUT stays 0, RISE never fires,
//     GLITCH_CNT=1, EVT_CNT unchanged.
//  4. 300 short glitches -> GLITCH_CNT saturates at 255. Then CLR=1 in the same cycle as a further
//     glitch -> GLITCH_CNT=0 on the next cycle.
//  5. From OUT=1, IN_RAW low and held -> FALL pulse and OUT=0 at edge 18. Then 256 clean toggles
//     -> EVT_CNT wraps back to its start value.
//  6. Assert RST while in ST_CHK_HI with IN_RAW held high -> all outputs 0 immediately (asynchronous).
//     After release, RISE fires at edge 18 and EVT_CNT=1.

Source files
------------

// File: rtl/in_debounce_sync.sv
// rtl/in_debounce_sync.sv - raw pin synchroniser, debouncer, edge pulses and event/glitch counters
module in_debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int EVT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_RAW,
    input  logic                CLR,
    output logic                OUT,
    output logic                RISE,
    output logic                FALL,
    output logic                BUSY,
    output logic [EVT_W-1:0]    EVT_CNT,
    output logic [GLITCH_W-1:0] GLITCH_CNT
);

    // Reject illegal parameter sets while elaborating.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("in_debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("in_debounce_sync: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((1 << CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cntw
        $error("in_debounce_sync: 2**CNT_W must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       dcnt;
    logic                   evt_inc;
    logic                   glitch_inc;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain; only the last stage is used.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], IN_RAW};
        end
    end

    // Debounce FSM: a change must persist for DEBOUNCE_CYCLES samples before OUT follows it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_LO;
            dcnt  <= '0;
            OUT   <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            case (state)
                ST_LO: begin
                    if (s) begin
                        state <= ST_CHK_HI;
                        dcnt  <= CNT_W'(1);
                        BUSY  <= 1'b1;
                    end
                end
                ST_CHK_HI: begin
                    if (!s) begin
                        state <= ST_LO;
                        dcnt  <= '0;
                        BUSY  <= 1'b0;
                    end else if (dcnt == DC_LAST) begin
                        state <= ST_HI;
                        dcnt  <= '0;
                        OUT   <= 1'b1;
                        RISE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state <= ST_CHK_LO;
                        dcnt  <= CNT_W'(1);
                        BUSY  <= 1'b1;
                    end
                end
                ST_CHK_LO: begin
                    if (s) begin
                        state <= ST_HI;
                        dcnt  <= '0;
                        BUSY  <= 1'b0;
                    end else if (dcnt == DC_LAST) begin
                        state <= ST_LO;
                        dcnt  <= '0;
                        OUT   <= 1'b0;
                        FALL  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LO;
                    dcnt  <= '0;
                    OUT   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // Flag accepted transitions and aborted checks for the counters.
    always_comb begin
        evt_inc    = 1'b0;
        glitch_inc = 1'b0;
        case (state)
            ST_CHK_HI: begin
                glitch_inc = !s;
                evt_inc    = s && (dcnt == DC_LAST);
            end
            ST_CHK_LO: begin
                glitch_inc = s;
                evt_inc    = !s && (dcnt == DC_LAST);
            end
            default: begin
                evt_inc    = 1'b0;
                glitch_inc = 1'b0;
            end
        endcase
    end

    // Event counter wraps, glitch counter saturates; CLR overrides any same-cycle increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EVT_CNT    <= '0;
            GLITCH_CNT <= '0;
        end else if (CLR) begin
            EVT_CNT    <= '0;
            GLITCH_CNT <= '0;
        end else begin
            if (evt_inc) begin
                EVT_CNT <= EVT_CNT + EVT_W'(1);
            end
            if (glitch_inc && (GLITCH_CNT != '1)) begin
                GLITCH_CNT <= GLITCH_CNT + GLITCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_in_debounce_sync.sv
// tb/tb_in_debounce_sync.sv - self-checking bench for in_debounce_sync against a run-length model
module tb_in_debounce_sync;

    localparam int SS = 2;
    localparam int DC = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       IN_RAW = 1'b0;
    logic       CLR = 1'b0;
    logic       OUT, RISE, FALL, BUSY;
    logic [7:0] EVT_CNT, GLITCH_CNT;

    in_debounce_sync #(
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(5), .EVT_W(8), .GLITCH_W(8)
    ) dut (
        .CLK(CLK), .RST(RST), .IN_RAW(IN_RAW), .CLR(CLR),
        .OUT(OUT), .RISE(RISE), .FALL(FALL), .BUSY(BUSY),
        .EVT_CNT(EVT_CNT), .GLITCH_CNT(GLITCH_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted level plus length of the current run of samples that disagree with it.
    bit m_q[$];
    bit m_out, m_rise, m_fall, m_busy;
    int m_run, m_evt, m_glitch;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
        m_out = 0; m_rise = 0; m_fall = 0; m_busy = 0;
        m_run = 0; m_evt = 0; m_glitch = 0;
    endtask

    function automatic bit will_glitch();
        return (m_q[0] == m_out) && (m_run > 0);
    endfunction

    task automatic model_step(bit in, bit clr);
        bit s;
        bit einc, ginc;
        s = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(in);
        m_rise = 0; m_fall = 0; einc = 0; ginc = 0;
        if (s != m_out) begin
            m_run++;
            if (m_run == DC) begin
                m_out  = s;
                m_rise = s;
                m_fall = !s;
                m_run  = 0;
                einc   = 1;
            end
        end else begin
            if (m_run > 0) ginc = 1;
            m_run = 0;
        end
        m_busy = (m_run > 0);
        if (clr) begin
            m_evt = 0; m_glitch = 0;
        end else begin
            m_evt = (m_evt + int'(einc)) % 256;
            if (ginc && m_glitch < 255) m_glitch++;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".out"},    32'(OUT),        32'(m_out));
        chk({tag, ".rise"},   32'(RISE),       32'(m_rise));
        chk({tag, ".fall"},   32'(FALL),       32'(m_fall));
        chk({tag, ".busy"},   32'(BUSY),       32'(m_busy));
        chk({tag, ".evt"},    32'(EVT_CNT),    32'(m_evt));
        chk({tag, ".glitch"}, 32'(GLITCH_CNT), 32'(m_glitch));
    endtask

    // One clock: advance the model at the rising edge, compare on the falling edge.
    task automatic tick(string tag);
        @(posedge CLK);
        if (!RST) model_reset();
        else model_step(IN_RAW, CLR);
        @(negedge CLK);
        chk_all(tag);
    endtask

    initial begin
        int t_out, t_rise, n_rise, n_busy, g0, e0, hit;

        // 1: reset state and idle
        model_reset();
        repeat (3) tick("rst");
        RST = 1'b1;
        repeat (50) tick("idle");

        // 2: clean rise, latency counted from the first sampling edge
        IN_RAW = 1'b1;
        t_out = 0; t_rise = 0; n_rise = 0; n_busy = 0;
        for (int i = 1; i <= 40; i++) begin
            tick("rise");
            if (BUSY) n_busy++;
            if (RISE) begin n_rise++; t_rise = i; end
            if (OUT === 1'b1 && t_out == 0) t_out = i;
        end
        chk("rise_out_edge", 32'(t_out), 32'd18);
        chk("rise_pulse_edge", 32'(t_rise), 32'd18);
        chk("rise_pulse_count", 32'(n_rise), 32'd1);
        chk("rise_busy_cycles", 32'(n_busy), 32'd15);
        chk("rise_evt", 32'(EVT_CNT), 32'd1);

        // 5a: clean fall
        IN_RAW = 1'b0;
        t_out = 0; n_rise = 0;
        for (int i = 1; i <= 40; i++) begin
            tick("fall");
            if (FALL) n_rise++;
            if (OUT === 1'b0 && t_out == 0) t_out = i;
        end
        chk("fall_out_edge", 32'(t_out), 32'd18);
        chk("fall_pulse_count", 32'(n_rise), 32'd1);

        // 3: 10-cycle pulse from OUT=0 is rejected
        g0 = m_glitch; e0 = m_evt; n_rise = 0;
        IN_RAW = 1'b1;
        for (int i = 0; i < 10; i++) begin tick("short_hi"); if (RISE) n_rise++; end
        IN_RAW = 1'b0;
        for (int i = 0; i < 10; i++) begin tick("short_lo"); if (RISE) n_rise++; end
        chk("short_no_rise", 32'(n_rise), 32'd0);
        chk("short_glitch", 32'(GLITCH_CNT), 32'(g0 + 1));
        chk("short_evt", 32'(EVT_CNT), 32'(e0));
        chk("short_out", 32'(OUT), 32'd0);

        // 4: glitch saturation, then CLR coincident with a further glitch
        for (int g = 0; g < 300; g++) begin
            IN_RAW = 1'b1; repeat (3) tick("glitch_hi");
            IN_RAW = 1'b0; repeat (4) tick("glitch_lo");
        end
        chk("glitch_sat", 32'(GLITCH_CNT), 32'd255);
        IN_RAW = 1'b1; repeat (3) tick("clr_hi");
        IN_RAW = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && hit == 0; i++) begin
            if (will_glitch()) begin CLR = 1'b1; hit = 1; end
            tick("clr_glitch");
            CLR = 1'b0;
        end
        chk("clr_hit", 32'(hit), 32'd1);
        chk("clr_glitch_zero", 32'(GLITCH_CNT), 32'd0);
        repeat (4) tick("clr_after");

        // 5b: 256 clean toggles wrap EVT_CNT back to its start value
        e0 = m_evt;
        for (int i = 0; i < 256; i++) begin
            IN_RAW = ~IN_RAW;
            repeat (20) tick("toggle");
        end
        chk("evt_wrap", 32'(EVT_CNT), 32'(e0));

        // Randomised runs with occasional CLR
        for (int r = 0; r < 300; r++) begin
            IN_RAW = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 24)) begin
                CLR = ($urandom_range(0, 49) == 0);
                tick("rand");
            end
            CLR = 1'b0;
        end

        // 6: asynchronous reset mid-check, then fresh rise after release
        IN_RAW = 1'b0; repeat (25) tick("pre6");
        IN_RAW = 1'b1; repeat (8) tick("chk6");
        chk("chk6_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge CLK);
        repeat (3) tick("rst6");
        RST = 1'b1;
        t_rise = 0;
        for (int i = 1; i <= 30; i++) begin
            tick("rerise");
            if (RISE && t_rise == 0) t_rise = i;
        end
        chk("rerise_edge", 32'(t_rise), 32'd18);
        chk("rerise_evt", 32'(EVT_CNT), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
